// File: rtl/pcs_an_pkg.sv
// Shared definitions for the 1000BASE-X PCS auto-negotiation controller.
// Provides the xmit encodings, the negotiation state enum, the ACK bit
// position and helpers that clear or set ACK in a 16-bit config word.
package pcs_an_pkg;

    localparam logic [2:0] XmitConfig = 3'b001;
    localparam logic [2:0] XmitIdle   = 3'b010;
    localparam logic [2:0] XmitData   = 3'b100;

    localparam int unsigned AckBit = 14;

    typedef enum logic [2:0] {
        StAnEnable,
        StAnRestart,
        StAbilityDetect,
        StAckDetect,
        StCompleteAck,
        StIdleDetect,
        StLinkOk
    } an_state_e;

    function automatic logic [15:0] clr_ack(input logic [15:0] word);
        logic [15:0] res;
        res         = word;
        res[AckBit] = 1'b0;
        return res;
    endfunction

    function automatic logic [15:0] set_ack(input logic [15:0] word);
        logic [15:0] res;
        res         = word;
        res[AckBit] = 1'b1;
        return res;
    endfunction

endpackage

// File: rtl/pcs_an_match.sv
// Qualifies received /C/ ordered sets for auto-negotiation.
// Ports:
//   clk, rst_n         clock and synchronous active-low reset
//   clear              drop all match history (asserted on a state change)
//   cfg_valid          one-cycle strobe: cfg_word holds a received config word
//   cfg_word           received config word
//   ability_match      same ACK-masked word seen on three consecutive strobes
//   ack_match          ability_match and ACK set on three consecutive strobes
//   stored_word        last ACK-masked word that started a match run
module pcs_an_match
    import pcs_an_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        cfg_valid,
    input  logic [15:0] cfg_word,
    output logic        ability_match,
    output logic        ack_match,
    output logic [15:0] stored_word
);

    logic [1:0]  cfg_cnt_q;
    logic [1:0]  ack_cnt_q;
    logic [15:0] word_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cfg_cnt_q <= 2'd0;
            ack_cnt_q <= 2'd0;
            word_q    <= 16'h0000;
        end else if (cfg_valid) begin
            if (clr_ack(cfg_word) == word_q) begin
                if (cfg_cnt_q != 2'd3) begin
                    cfg_cnt_q <= cfg_cnt_q + 2'd1;
                end
            end else begin
                // A new word restarts the run and counts as its first sighting.
                cfg_cnt_q <= 2'd1;
                word_q    <= clr_ack(cfg_word);
            end
            if (cfg_word[AckBit]) begin
                if (ack_cnt_q != 2'd3) begin
                    ack_cnt_q <= ack_cnt_q + 2'd1;
                end
            end else begin
                ack_cnt_q <= 2'd0;
            end
        end
    end

    assign ability_match = (cfg_cnt_q == 2'd3);
    assign ack_match     = (ack_cnt_q == 2'd3) && ability_match;
    assign stored_word   = word_q;

endmodule

// File: rtl/pcs_an_ctrl.sv
// Reduced Clause 37 auto-negotiation controller for the 1000BASE-X PCS.
// Sequences xmit (CONFIGURATION -> IDLE -> DATA), drives the advertised
// config word and latches the link partner's ability.
// Ports:
//   GTX_CLK, mr_main_reset   clock and synchronous active-low reset
//   mr_an_enable             1 = negotiate, 0 = go straight to DATA on sync
//   mr_restart_an            level-sensitive negotiation restart
//   mr_adv_ability           local ability word (ACK bit ignored)
//   sync_status              receive synchronizer locked
//   rx_config_valid/_reg     received /C/ strobe and word
//   rx_idle                  /I/ currently being received
//   xmit                     one-hot transmit mode
//   tx_config_reg            config word to transmit
//   mr_lp_adv_ability        latched link-partner ability
//   mr_an_complete, link_ok  status flags
module pcs_an_ctrl
    import pcs_an_pkg::*;
#(
    parameter int unsigned LINK_TIMER = 1250000,
    parameter int unsigned TMR_W      = $clog2(LINK_TIMER)
) (
    input  logic        GTX_CLK,
    input  logic        mr_main_reset,
    input  logic        mr_an_enable,
    input  logic        mr_restart_an,
    input  logic [15:0] mr_adv_ability,
    input  logic        sync_status,
    input  logic        rx_config_valid,
    input  logic [15:0] rx_config_reg,
    input  logic        rx_idle,
    output logic [2:0]  xmit,
    output logic [15:0] tx_config_reg,
    output logic [15:0] mr_lp_adv_ability,
    output logic        mr_an_complete,
    output logic        link_ok
);

    localparam logic [TMR_W-1:0] TmrLoad = TMR_W'(LINK_TIMER - 1);

    an_state_e        state_q, state_d;
    logic [TMR_W-1:0] timer_q;
    logic             timer_zero;
    logic             restart_req;
    logic             state_change;
    logic             tmr_load;
    logic             tmr_run;
    logic             ability_match;
    logic             ack_match;
    logic [15:0]      stored_word;

    pcs_an_match u_match (
        .clk           (GTX_CLK),
        .rst_n         (mr_main_reset),
        .clear         (state_change),
        .cfg_valid     (rx_config_valid),
        .cfg_word      (rx_config_reg),
        .ability_match (ability_match),
        .ack_match     (ack_match),
        .stored_word   (stored_word)
    );

    assign timer_zero   = (timer_q == '0);
    assign restart_req  = mr_restart_an && mr_an_enable;
    assign state_change = (state_d != state_q);

    always_comb begin
        state_d = state_q;
        if (!sync_status && state_q != StAnEnable) begin
            state_d = StAnEnable;
        end else if (restart_req) begin
            state_d = StAnRestart;
        end else begin
            case (state_q)
                StAnEnable: begin
                    if (mr_an_enable)     state_d = StAnRestart;
                    else if (sync_status) state_d = StLinkOk;
                end
                StAnRestart: begin
                    if (timer_zero) state_d = StAbilityDetect;
                end
                StAbilityDetect: begin
                    if (ability_match && stored_word != 16'h0000) state_d = StAckDetect;
                end
                StAckDetect: begin
                    if (ack_match) begin
                        state_d = StCompleteAck;
                    end else if (ability_match && stored_word == 16'h0000) begin
                        state_d = StAnEnable;
                    end
                end
                StCompleteAck: begin
                    if (timer_zero) state_d = StIdleDetect;
                end
                StIdleDetect: begin
                    if (rx_idle && timer_zero) state_d = StLinkOk;
                end
                StLinkOk: begin
                    if (mr_an_enable && rx_config_valid) state_d = StAnEnable;
                end
                default: state_d = StAnEnable;
            endcase
        end
    end

    // Reload on entry to a timed state, while restart is held, and whenever
    // IDLE_DETECT sees a non-idle cycle.
    always_comb begin
        tmr_load = 1'b0;
        if (state_change && (state_d == StAnRestart || state_d == StCompleteAck ||
                             state_d == StIdleDetect)) begin
            tmr_load = 1'b1;
        end
        if (state_d == StAnRestart && restart_req) begin
            tmr_load = 1'b1;
        end
        if (state_q == StIdleDetect && state_d == StIdleDetect && !rx_idle) begin
            tmr_load = 1'b1;
        end
        tmr_run = !state_change && (state_q == StAnRestart || state_q == StCompleteAck ||
                                    state_q == StIdleDetect);
    end

    // Outputs are registered from the next state so they move on the same
    // edge as the state register.
    always_ff @(posedge GTX_CLK) begin
        if (!mr_main_reset) begin
            state_q           <= StAnEnable;
            timer_q           <= '0;
            xmit              <= XmitConfig;
            tx_config_reg     <= 16'h0000;
            mr_lp_adv_ability <= 16'h0000;
            mr_an_complete    <= 1'b0;
            link_ok           <= 1'b0;
        end else begin
            state_q <= state_d;

            if (tmr_load) begin
                timer_q <= TmrLoad;
            end else if (tmr_run && !timer_zero) begin
                timer_q <= timer_q - 1'b1;
            end

            case (state_d)
                StIdleDetect: xmit <= XmitIdle;
                StLinkOk:     xmit <= XmitData;
                default:      xmit <= XmitConfig;
            endcase

            case (state_d)
                StAnEnable, StAnRestart: tx_config_reg <= 16'h0000;
                StAbilityDetect:         tx_config_reg <= clr_ack(mr_adv_ability);
                StAckDetect:             tx_config_reg <= set_ack(mr_adv_ability);
                default:                 tx_config_reg <= tx_config_reg;
            endcase

            if (state_q == StAckDetect && state_d == StCompleteAck) begin
                mr_lp_adv_ability <= stored_word;
            end

            mr_an_complete <= (state_d == StLinkOk) && mr_an_enable;
            link_ok        <= (state_d == StLinkOk);
        end
    end

endmodule

// File: tb/tb_pcs_an_ctrl.sv
// Self-checking bench for pcs_an_ctrl with LINK_TIMER = 8. Stimulus pushes the
// expected output snapshot and the cycle it must appear in; the monitor pops
// one entry every time the DUT output tuple changes.
module tb_pcs_an_ctrl;

    typedef struct packed {
        logic [2:0]  xmit;
        logic [15:0] tx;
        logic [15:0] lp;
        logic        cmpl;
        logic        ok;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        an_enable;
    logic        restart_an;
    logic [15:0] adv;
    logic        sync_ok;
    logic        cfg_valid;
    logic [15:0] cfg_reg;
    logic        idle;
    logic [2:0]  xmit;
    logic [15:0] tx_cfg;
    logic [15:0] lp_adv;
    logic        an_cmpl;
    logic        lnk_ok;

    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    int    exp_cyc_q[$];
    snap_t exp_q[$];

    pcs_an_ctrl #(.LINK_TIMER(8)) dut (
        .GTX_CLK           (clk),
        .mr_main_reset     (rst_n),
        .mr_an_enable      (an_enable),
        .mr_restart_an     (restart_an),
        .mr_adv_ability    (adv),
        .sync_status       (sync_ok),
        .rx_config_valid   (cfg_valid),
        .rx_config_reg     (cfg_reg),
        .rx_idle           (idle),
        .xmit              (xmit),
        .tx_config_reg     (tx_cfg),
        .mr_lp_adv_ability (lp_adv),
        .mr_an_complete    (an_cmpl),
        .link_ok           (lnk_ok)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [2:0] x, input logic [15:0] t,
                        input logic [15:0] l, input logic cm, input logic o);
        snap_t s;
        s.xmit = x;
        s.tx   = t;
        s.lp   = l;
        s.cmpl = cm;
        s.ok   = o;
        exp_cyc_q.push_back(c);
        exp_q.push_back(s);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: one comparison per observed output change.
    snap_t act, prev, need;
    int    need_cyc;
    bit    have_prev = 1'b0;
    int    evt = 0;
    always @(negedge clk) begin
        act.xmit = xmit;
        act.tx   = tx_cfg;
        act.lp   = lp_adv;
        act.cmpl = an_cmpl;
        act.ok   = lnk_ok;
        if (!have_prev || act != prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL evt%0d unexpected: got cyc=%0d xmit=%b tx=%h lp=%h cmpl=%b ok=%b, need no change",
                         evt, cyc, act.xmit, act.tx, act.lp, act.cmpl, act.ok);
            end else begin
                need     = exp_q.pop_front();
                need_cyc = exp_cyc_q.pop_front();
                if (act != need || cyc != need_cyc) begin
                    failures++;
                    $display("FAIL evt%0d: got cyc=%0d xmit=%b tx=%h lp=%h cmpl=%b ok=%b, need cyc=%0d xmit=%b tx=%h lp=%h cmpl=%b ok=%b",
                             evt, cyc, act.xmit, act.tx, act.lp, act.cmpl, act.ok,
                             need_cyc, need.xmit, need.tx, need.lp, need.cmpl, need.ok);
                end
            end
            evt++;
            prev      = act;
            have_prev = 1'b1;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got cyc=%0d, need completion", cyc);
        $fatal(1, "watchdog expired");
    end

    int r, l, r2, a, i_ent, x, y;
    initial begin
        rst_n      = 1'b0;
        an_enable  = 1'b0;
        restart_an = 1'b0;
        adv        = 16'h01A0;
        sync_ok    = 1'b0;
        cfg_valid  = 1'b0;
        cfg_reg    = 16'h0000;
        idle       = 1'b1;

        // Reset values; no sync so the block stays put after release.
        push(1, 3'b001, 16'h0000, 16'h0000, 1'b0, 1'b0);
        wait_until(3);
        rst_n = 1'b1;
        wait_until(7);

        // Full handshake via restart.
        sync_ok    = 1'b1;
        an_enable  = 1'b1;
        restart_an = 1'b1;
        r = cyc + 1;
        wait_until(r);
        restart_an = 1'b0;
        push(r + 8,  3'b001, 16'h01A0, 16'h0000, 1'b0, 1'b0);
        push(r + 12, 3'b001, 16'h41A0, 16'h0000, 1'b0, 1'b0);
        push(r + 16, 3'b001, 16'h41A0, 16'h0020, 1'b0, 1'b0);
        push(r + 24, 3'b010, 16'h41A0, 16'h0020, 1'b0, 1'b0);
        push(r + 32, 3'b100, 16'h41A0, 16'h0020, 1'b1, 1'b1);
        wait_until(r + 8);
        cfg_valid = 1'b1;
        cfg_reg   = 16'h4020;
        wait_until(r + 15);
        cfg_valid = 1'b0;
        wait_until(r + 34);

        // Sync loss together with restart: AN_ENABLE first, then AN_RESTART.
        l = cyc;
        sync_ok    = 1'b0;
        restart_an = 1'b1;
        push(l + 1, 3'b001, 16'h0000, 16'h0020, 1'b0, 1'b0);
        wait_until(l + 1);
        sync_ok    = 1'b1;
        restart_an = 1'b0;
        r2 = l + 2;

        // Reach ACK_DETECT, then three null pages send it back to AN_ENABLE.
        a = r2 + 25;
        push(r2 + 8,  3'b001, 16'h01A0, 16'h0020, 1'b0, 1'b0);
        push(r2 + 12, 3'b001, 16'h41A0, 16'h0020, 1'b0, 1'b0);
        push(r2 + 16, 3'b001, 16'h0000, 16'h0020, 1'b0, 1'b0);
        push(a,       3'b001, 16'h01A0, 16'h0020, 1'b0, 1'b0);
        wait_until(r2 + 8);
        cfg_valid = 1'b1;
        cfg_reg   = 16'h0020;
        wait_until(r2 + 11);
        cfg_reg   = 16'h0000;
        wait_until(r2 + 15);
        cfg_valid = 1'b0;

        // Handshake again; idle drops for one cycle during IDLE_DETECT.
        i_ent = a + 16;
        push(a + 4,      3'b001, 16'h41A0, 16'h0020, 1'b0, 1'b0);
        push(i_ent,      3'b010, 16'h41A0, 16'h0020, 1'b0, 1'b0);
        push(i_ent + 13, 3'b100, 16'h41A0, 16'h0020, 1'b1, 1'b1);
        wait_until(a);
        cfg_valid = 1'b1;
        cfg_reg   = 16'h4020;
        wait_until(a + 7);
        cfg_valid = 1'b0;
        wait_until(i_ent + 4);
        idle = 1'b0;
        wait_until(i_ent + 5);
        idle = 1'b1;
        wait_until(i_ent + 15);

        // Reset from LINK_OK, then bypass mode straight to LINK_OK.
        x = cyc;
        rst_n = 1'b0;
        push(x + 1, 3'b001, 16'h0000, 16'h0000, 1'b0, 1'b0);
        wait_until(x + 1);
        rst_n     = 1'b1;
        an_enable = 1'b0;
        push(x + 2, 3'b100, 16'h0000, 16'h0000, 1'b0, 1'b1);

        // In bypass a /C/ is ignored; with negotiation enabled it drops the link.
        wait_until(x + 4);
        cfg_valid = 1'b1;
        cfg_reg   = 16'h0000;
        wait_until(x + 5);
        y = cyc;
        an_enable = 1'b1;
        push(y + 1, 3'b001, 16'h0000, 16'h0000, 1'b0, 1'b0);
        wait_until(y + 1);
        cfg_valid = 1'b0;
        an_enable = 1'b0;
        sync_ok   = 1'b0;
        wait_until(y + 6);
        @(negedge clk);
        #1;

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending events, need 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pcs_an_ctrl.md
# pcs_an_ctrl

Link controller for the 1000BASE-X PCS: a reduced Clause 37 auto-negotiation state machine that sequences the PCS `xmit` control (CONFIGURATION → IDLE → DATA). It drives the advertised `tx_config_reg` toward the transmit path and qualifies received /C/ and /I/ ordered sets from the receive path. It sits beside the PCS in the GTX_CLK domain and replaces the tester as the source of `xmit` in the integrated design.

## Interface
- `LINK_TIMER`, default 1250000 (10 ms at 125 MHz): link timer length in cycles. Benches use 8.
- `TMR_W`, default `$clog2(LINK_TIMER)`: timer counter width.

Ports, clock and reset first:
- `GTX_CLK` in 1: single clock.
- `mr_main_reset` in 1: synchronous, active-low; 0 on a GTX_CLK edge resets the block.
- `mr_an_enable` in 1: 1 = run auto-negotiation; 0 = bypass to DATA.
- `mr_restart_an` in 1: level, restart negotiation.
- `mr_adv_ability` in 16: local ability word. Bit 14 (ACK) is ignored.
- `sync_status` in 1: receive synchronizer OK.
- `rx_config_valid` in 1: one-cycle strobe, a /C/ set was received.
- `rx_config_reg` in 16: received config word, valid with the strobe.
- `rx_idle` in 1: /I/ currently being received.
- `xmit` out 3: 3'b001 CONFIGURATION, 3'b010 IDLE, 3'b100 DATA.
- `tx_config_reg` out 16: config word to transmit.
- `mr_lp_adv_ability` out 16: latched link-partner ability.
- `mr_an_complete` out 1: negotiation done.
- `link_ok` out 1: state is LINK_OK.

## Operation
- States: AN_ENABLE, AN_RESTART, ABILITY_DETECT, ACK_DETECT, COMPLETE_ACK, IDLE_DETECT, LINK_OK.
- Reset values: state AN_ENABLE, `xmit` = 001, `tx_config_reg` = 0, `mr_lp_adv_ability` = 0, `mr_an_complete` = 0, `link_ok` = 0, timer = 0, match counters = 0.
- Match logic, updated on `rx_config_valid` only:
  - cfg_cnt: compares `rx_config_reg` with bit 14 masked against the stored word. Equal → saturating increment to 3. Different → cnt = 1 and the word is stored.
  - `ability_match` = cfg_cnt == 3.
  - ack_cnt: counts consecutive strobes with bit 14 = 1 (saturating at 3); any strobe with bit 14 = 0 → 0.
  - `ack_match` = ack_cnt == 3 and `ability_match`.
  - Matches clear on every state change.
- State behaviour:
  - AN_ENABLE: `xmit` = CONFIG, tx_config = 0. If `mr_an_enable` → AN_RESTART. Otherwise, if `sync_status` → LINK_OK.
  - AN_RESTART: tx_config = 0, timer runs. Expiry → ABILITY_DETECT.
  - ABILITY_DETECT: tx_config = `mr_adv_ability` with bit 14 = 0. `ability_match` with stored word ≠ 0 → ACK_DETECT.
  - ACK_DETECT: tx_config = `mr_adv_ability` with bit 14 = 1.
    - `ack_match` → COMPLETE_ACK, and `mr_lp_adv_ability` latches the stored word.
    - `ability_match` with stored word == 0 → AN_ENABLE.
  - COMPLETE_ACK: tx_config is held, timer runs. Expiry → IDLE_DETECT.
  - IDLE_DETECT: `xmit` = IDLE, timer runs. Any cycle with `rx_idle` = 0 reloads the timer. Expiry → LINK_OK.
  - LINK_OK: `xmit` = DATA, `mr_an_complete` = 1 (only when `mr_an_enable`), `link_ok` = 1. With `mr_an_enable` = 1, any `rx_config_valid` → AN_ENABLE.
- Global priority, highest first:
  1. reset
  2. `sync_status` = 0 in any state other than AN_ENABLE → AN_ENABLE
  3. `mr_restart_an` = 1 with `mr_an_enable` → AN_RESTART (held there while the level stays high)
  4. local transitions

## Timing
- All outputs are registered and reflect the new state one cycle after the triggering input edge.
- Link timer:
  - Loaded with LINK_TIMER−1 on entry to AN_RESTART, COMPLETE_ACK and IDLE_DETECT; decrements every cycle.
  - Expiry occurs in the cycle the timer equals 0, so the transition happens exactly LINK_TIMER cycles after entry.
  - The timer is frozen in other states.
- Third matching `rx_config_valid` at edge N → `ability_match` visible at edge N+1 → state change at edge N+1 (the match is combinational from the counter).
- Reset mid-negotiation: the next edge returns every output to its reset value, regardless of the timer.
- Simultaneous `sync_status` = 0 and `mr_restart_an`: AN_ENABLE wins.

## Structure
- Package `pcs_an_pkg`: `xmit` encodings, state enum, ACK bit index (14).
- Sub-module `pcs_an_match`: cfg_cnt/ack_cnt counters with a clear input; outputs `ability_match`, `ack_match` and the stored word.
- Top-level: FSM, link timer, output registers.

## Test plan
All scenarios use LINK_TIMER = 8.
- Reset low 3 cycles, then high with `sync_status` = 0 → `xmit` = 001, tx_config = 0, all flags 0, state stays AN_ENABLE.
- Full handshake:
  - Stimulus: adv 0x01A0, `sync_status` = 1. Feed 3× 0x4020 after entering ABILITY_DETECT; this matches with ACK set, so cfg_cnt and ack_cnt both reach 3 on the same strobes.
  - Required response: ABILITY_DETECT 8 cycles after restart, tx_config 0x01A0 → 0x41A0. `mr_lp_adv_ability` = 0x0020 (bit 14 masked). `xmit` = 010 8 cycles later. With `rx_idle` = 1, `xmit` = 100 and `mr_an_complete` = 1 after 8 more cycles.
- ACK_DETECT with 3× 0x0000 received → return to AN_ENABLE, tx_config = 0.
- IDLE_DETECT with `rx_idle` dropped at cycle 5 → timer reloads, LINK_OK reached 8 cycles after `rx_idle` returns.
- LINK_OK then `sync_status` = 0 one cycle → next edge `xmit` = 001, `link_ok` = 0, `mr_an_complete` = 0.
- `mr_an_enable` = 0, `sync_status` = 1 → LINK_OK one cycle after reset release, `xmit` = 100, `mr_an_complete` = 0.
